exe_stage_mc: RTL and testbench

Parametrised multi-cycle execute stage for the MIPS pipeline, sitting between the ID/EXE and EXE/MEM registers.
- Single-cycle ALU ops, branch-target and branch-condition evaluation complete in one cycle.
- Unsigned multiply and divide run on an iterative radix-2 unit. The stage holds a HI register and raises stall to the hazard unit while the unit is busy.
- All results leave through registered outputs qualified by out_valid.

---
 rtl/exe_pkg.sv | 27 ++
 rtl/iter_muldiv.sv | 81 ++++++++
 rtl/exe_stage_mc.sv | 132 +++++++++++++
 tb/tb_exe_stage_mc.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/exe_pkg.sv
// Execute-stage command and branch-type encodings shared by the EXE datapath.
package exe_pkg;

  localparam logic [3:0] EXE_ADD  = 4'b0000;
  localparam logic [3:0] EXE_SUB  = 4'b0010;
  localparam logic [3:0] EXE_AND  = 4'b0100;
  localparam logic [3:0] EXE_OR   = 4'b0101;
  localparam logic [3:0] EXE_NOR  = 4'b0110;
  localparam logic [3:0] EXE_XOR  = 4'b0111;
  localparam logic [3:0] EXE_SLL  = 4'b1000;
  localparam logic [3:0] EXE_SRA  = 4'b1001;
  localparam logic [3:0] EXE_SRL  = 4'b1010;
  localparam logic [3:0] EXE_MULU = 4'b1100;
  localparam logic [3:0] EXE_DIVU = 4'b1101;
  localparam logic [3:0] EXE_MFHI = 4'b1110;
  localparam logic [3:0] EXE_NOP  = 4'b1111;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BEZ  = 2'b01;
  localparam logic [1:0] BR_BNE  = 2'b10;
  localparam logic [1:0] BR_JMP  = 2'b11;

  function automatic logic is_multicycle(input logic [3:0] cmd);
    return (cmd == EXE_MULU) || (cmd == EXE_DIVU);
  endfunction

endpackage

// File: rtl/iter_muldiv.sv
// Radix-2 iterative unsigned multiplier / restoring divider, one bit per cycle.
module iter_muldiv
  import exe_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         is_div,
  input  logic                         flush,
  input  logic [DATA_W-1:0]            op_a,
  input  logic [DATA_W-1:0]            op_b,
  output logic [$clog2(DATA_W):0]      cnt,
  output logic                         done_c,
  output logic [DATA_W-1:0]            lo_c,
  output logic [DATA_W-1:0]            hi_c
);

  localparam int unsigned CNT_W = $clog2(DATA_W) + 1;

  logic              div_q;
  logic [DATA_W-1:0] op_b_q;
  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] lo_q;
  logic [DATA_W-1:0] rem_n;
  logic [DATA_W-1:0] lo_n;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   shifted;

  // One iteration: mul shifts {acc,lo} right after add; div shifts {rem,lo} left then trial-subtracts
  always_comb begin
    sum     = '0;
    shifted = '0;
    rem_n   = rem_q;
    lo_n    = lo_q;
    if (div_q) begin
      shifted = {rem_q, lo_q[DATA_W-1]};
      if (shifted >= {1'b0, op_b_q}) begin
        rem_n = DATA_W'(shifted - {1'b0, op_b_q});
        lo_n  = {lo_q[DATA_W-2:0], 1'b1};
      end else begin
        rem_n = DATA_W'(shifted);
        lo_n  = {lo_q[DATA_W-2:0], 1'b0};
      end
    end else begin
      sum   = {1'b0, rem_q} + (lo_q[0] ? {1'b0, op_b_q} : '0);
      rem_n = sum[DATA_W:1];
      lo_n  = {sum[0], lo_q[DATA_W-1:1]};
    end
  end

  assign done_c = (cnt == CNT_W'(1)) && !flush;
  assign lo_c   = lo_n;
  assign hi_c   = rem_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      div_q  <= 1'b0;
      op_b_q <= '0;
      rem_q  <= '0;
      lo_q   <= '0;
    end else if (start) begin
      cnt    <= CNT_W'(DATA_W);
      div_q  <= is_div;
      op_b_q <= op_b;
      rem_q  <= '0;
      lo_q   <= op_a;
    end else if (cnt != '0) begin
      if (flush) begin
        cnt <= '0;
      end else begin
        cnt   <= cnt - CNT_W'(1);
        rem_q <= rem_n;
        lo_q  <= lo_n;
      end
    end
  end

endmodule

// File: rtl/exe_stage_mc.sv
// MIPS execute stage: single-cycle ALU and branch resolution plus an iterative MULU/DIVU with HI.
module exe_stage_mc
  import exe_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned OFFS_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     flush,
  input  logic [3:0]               exe_cmd,
  input  logic [DATA_W-1:0]        val1,
  input  logic [DATA_W-1:0]        val2,
  input  logic [DATA_W-1:0]        val_src2,
  input  logic [ADDR_W-1:0]        pc,
  input  logic [1:0]               br_type,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        alu_result,
  output logic [ADDR_W-1:0]        br_addr,
  output logic                     br_taken,
  output logic                     stall,
  output logic [$clog2(DATA_W):0]  busy_cnt
);

  localparam int unsigned SH_W = $clog2(DATA_W);

  typedef enum logic {IDLE, ITER} state_t;

  state_t            state;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] alu_c;
  logic              cond_c;
  logic [ADDR_W-1:0] br_addr_c;
  logic [ADDR_W-1:0] offs_ext;
  logic [SH_W-1:0]   shamt;
  logic              accept_c;
  logic              start_c;
  logic              done_c;
  logic [DATA_W-1:0] md_lo_c;
  logic [DATA_W-1:0] md_hi_c;

  assign accept_c = (state == IDLE) && in_valid && !flush;
  assign start_c  = accept_c && is_multicycle(exe_cmd);
  assign shamt    = val2[SH_W-1:0];
  assign stall    = (state == ITER);

  always_comb begin
    alu_c = '0;
    case (exe_cmd)
      EXE_ADD:  alu_c = val1 + val2;
      EXE_SUB:  alu_c = val1 - val2;
      EXE_AND:  alu_c = val1 & val2;
      EXE_OR:   alu_c = val1 | val2;
      EXE_NOR:  alu_c = ~(val1 | val2);
      EXE_XOR:  alu_c = val1 ^ val2;
      EXE_SLL:  alu_c = val1 << shamt;
      EXE_SRA:  alu_c = DATA_W'($signed(val1) >>> shamt);
      EXE_SRL:  alu_c = val1 >> shamt;
      EXE_MFHI: alu_c = hi;
      default:  alu_c = '0;
    endcase
  end

  always_comb begin
    cond_c = 1'b0;
    case (br_type)
      BR_BEZ:  cond_c = (val1 == '0);
      BR_BNE:  cond_c = (val1 != val_src2);
      BR_JMP:  cond_c = 1'b1;
      default: cond_c = 1'b0;
    endcase
  end

  assign offs_ext  = ADDR_W'($signed(val2[OFFS_W-1:0]));
  assign br_addr_c = pc + ADDR_W'(4) + (offs_ext << 2);

  iter_muldiv #(.DATA_W(DATA_W)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (start_c),
    .is_div (exe_cmd == EXE_DIVU),
    .flush  (flush),
    .op_a   (val1),
    .op_b   (val2),
    .cnt    (busy_cnt),
    .done_c (done_c),
    .lo_c   (md_lo_c),
    .hi_c   (md_hi_c)
  );

  // Flush beats completion in ITER, so an aborted op never writes HI or pulses out_valid
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      alu_result <= '0;
      br_addr    <= '0;
      br_taken   <= 1'b0;
      hi         <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_c) begin
            br_addr  <= br_addr_c;
            br_taken <= cond_c && !is_multicycle(exe_cmd);
            if (is_multicycle(exe_cmd)) begin
              state <= ITER;
            end else begin
              out_valid  <= 1'b1;
              alu_result <= alu_c;
            end
          end
        end
        ITER: begin
          if (flush) begin
            state <= IDLE;
          end else if (done_c) begin
            state      <= IDLE;
            out_valid  <= 1'b1;
            alu_result <= md_lo_c;
            hi         <= md_hi_c;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exe_stage_mc.sv
// Directed self-checking bench for exe_stage_mc with hand-computed expectations.
module tb_exe_stage_mc;
  import exe_pkg::*;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned OFFS_W = 16;
  localparam int unsigned CNT_W  = $clog2(DATA_W) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              flush;
  logic [3:0]        exe_cmd;
  logic [DATA_W-1:0] val1;
  logic [DATA_W-1:0] val2;
  logic [DATA_W-1:0] val_src2;
  logic [ADDR_W-1:0] pc;
  logic [1:0]        br_type;
  logic              out_valid;
  logic [DATA_W-1:0] alu_result;
  logic [ADDR_W-1:0] br_addr;
  logic              br_taken;
  logic              stall;
  logic [CNT_W-1:0]  busy_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int nst;

  always #5 clk = ~clk;

  exe_stage_mc #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OFFS_W(OFFS_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .flush      (flush),
    .exe_cmd    (exe_cmd),
    .val1       (val1),
    .val2       (val2),
    .val_src2   (val_src2),
    .pc         (pc),
    .br_type    (br_type),
    .out_valid  (out_valid),
    .alu_result (alu_result),
    .br_addr    (br_addr),
    .br_taken   (br_taken),
    .stall      (stall),
    .busy_cnt   (busy_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] cmd, input logic [31:0] v1, input logic [31:0] v2,
                       input logic [31:0] vs2, input logic [31:0] p, input logic [1:0] br);
    exe_cmd  = cmd;
    val1     = v1;
    val2     = v2;
    val_src2 = vs2;
    pc       = p;
    br_type  = br;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Counts stall cycles until out_valid; returns in the completion cycle
  task automatic wait_done(output int n);
    bit ok;
    n  = 0;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (out_valid) begin
        ok = 1;
        break;
      end
      if (stall) n++;
      step();
    end
    if (!ok) chk("done_timeout", 64'(0), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; exe_cmd = EXE_NOP;
    val1 = '0; val2 = '0; val_src2 = '0; pc = '0; br_type = BR_NONE;
    step(); step();
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_stall", 64'(stall), 64'(0));
    chk("rst_cnt", 64'(busy_cnt), 64'(0));
    rst = 1'b0;

    // Single-cycle ALU
    issue(EXE_ADD, 32'h5, 32'hFFFF_FFFE, 0, 32'h0, BR_NONE);
    chk("add_valid", 64'(out_valid), 64'(1));
    chk("add_res", 64'(alu_result), 64'h3);
    chk("add_stall", 64'(stall), 64'(0));
    chk("add_taken", 64'(br_taken), 64'(0));
    step();
    chk("add_pulse", 64'(out_valid), 64'(0));
    chk("add_hold", 64'(alu_result), 64'h3);
    issue(EXE_SUB, 32'h0, 32'h1, 0, 0, BR_NONE);
    chk("sub_wrap", 64'(alu_result), 64'hFFFF_FFFF);
    issue(EXE_SRA, 32'h8000_0000, 32'h4, 0, 0, BR_NONE);
    chk("sra", 64'(alu_result), 64'hF800_0000);
    issue(EXE_SRL, 32'h8000_0000, 32'h4, 0, 0, BR_NONE);
    chk("srl", 64'(alu_result), 64'h0800_0000);
    issue(EXE_SLL, 32'h1, 32'h3F, 0, 0, BR_NONE);
    chk("sll_shamt", 64'(alu_result), 64'h8000_0000);
    issue(EXE_NOR, 32'h0F0F_0000, 32'h0000_00FF, 0, 0, BR_NONE);
    chk("nor", 64'(alu_result), 64'hF0F0_FF00);
    issue(EXE_XOR, 32'hFF00_FF00, 32'h0FF0_0FF0, 0, 0, BR_NONE);
    chk("xor", 64'(alu_result), 64'hF0F0_F0F0);

    // Branches
    issue(EXE_ADD, 32'h7, 32'h0000_FFFE, 32'h8, 32'h100, BR_BNE);
    chk("bne_taken", 64'(br_taken), 64'(1));
    chk("bne_addr", 64'(br_addr), 64'hFC);
    issue(EXE_ADD, 32'h8, 32'h0000_0010, 32'h8, 32'h100, BR_BNE);
    chk("bne_eq", 64'(br_taken), 64'(0));
    chk("bne_addr2", 64'(br_addr), 64'h144);
    issue(EXE_ADD, 32'h0, 32'h0000_FFFE, 32'h3, 32'h100, BR_BEZ);
    chk("bez_taken", 64'(br_taken), 64'(1));
    chk("bez_addr", 64'(br_addr), 64'hFC);
    issue(EXE_ADD, 32'h5, 32'h0000_FFFE, 32'h3, 32'h100, BR_BEZ);
    chk("bez_not", 64'(br_taken), 64'(0));

    // MULU with JMP type: taken forced low
    issue(EXE_MULU, 32'hFFFF_FFFF, 32'h2, 0, 32'h40, BR_JMP);
    chk("mul_cnt0", 64'(busy_cnt), 64'(32));
    wait_done(nst);
    chk("mul_stalls", 64'(nst), 64'(32));
    chk("mul_res", 64'(alu_result), 64'hFFFF_FFFE);
    chk("mul_stall_fall", 64'(stall), 64'(0));
    chk("mul_taken", 64'(br_taken), 64'(0));
    chk("mul_addr", 64'(br_addr), 64'h4C);
    step();
    issue(EXE_MFHI, 0, 0, 0, 0, BR_NONE);
    chk("mul_hi", 64'(alu_result), 64'h1);

    // DIVU with an ADD held on the inputs during the stall
    issue(EXE_DIVU, 32'd100, 32'd7, 0, 0, BR_NONE);
    exe_cmd = EXE_ADD; val1 = 32'h1; val2 = 32'h2; pc = 32'h200; br_type = BR_NONE;
    in_valid = 1'b1;
    wait_done(nst);
    chk("div_stalls", 64'(nst), 64'(32));
    chk("div_q", 64'(alu_result), 64'd14);
    chk("div_stall_fall", 64'(stall), 64'(0));
    step();
    in_valid = 1'b0;
    chk("held_valid", 64'(out_valid), 64'(1));
    chk("held_res", 64'(alu_result), 64'h3);
    chk("held_addr", 64'(br_addr), 64'h20C);
    issue(EXE_MFHI, 0, 0, 0, 0, BR_NONE);
    chk("div_r", 64'(alu_result), 64'd2);

    issue(EXE_DIVU, 32'd9, 32'd0, 0, 0, BR_NONE);
    wait_done(nst);
    chk("div0_stalls", 64'(nst), 64'(32));
    chk("div0_q", 64'(alu_result), 64'hFFFF_FFFF);
    step();
    issue(EXE_MFHI, 0, 0, 0, 0, BR_NONE);
    chk("div0_hi", 64'(alu_result), 64'd9);

    // Flush in iteration 10
    issue(EXE_MULU, 32'd3, 32'd5, 0, 0, BR_NONE);
    repeat (9) step();
    chk("fl10_cnt", 64'(busy_cnt), 64'(23));
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl10_valid", 64'(out_valid), 64'(0));
    chk("fl10_stall", 64'(stall), 64'(0));
    chk("fl10_cnt0", 64'(busy_cnt), 64'(0));
    issue(EXE_MFHI, 0, 0, 0, 0, BR_NONE);
    chk("fl10_hi", 64'(alu_result), 64'd9);

    // Flush in the final iteration, then an immediate ADD
    issue(EXE_MULU, 32'd3, 32'd5, 0, 0, BR_NONE);
    repeat (31) step();
    chk("flL_cnt", 64'(busy_cnt), 64'(1));
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flL_valid", 64'(out_valid), 64'(0));
    chk("flL_stall", 64'(stall), 64'(0));
    issue(EXE_ADD, 32'd10, 32'd20, 0, 0, BR_NONE);
    chk("flL_add_valid", 64'(out_valid), 64'(1));
    chk("flL_add", 64'(alu_result), 64'd30);
    issue(EXE_MFHI, 0, 0, 0, 0, BR_NONE);
    chk("flL_hi", 64'(alu_result), 64'd9);

    // Flush in IDLE drops the concurrent input
    flush = 1'b1;
    issue(EXE_ADD, 32'd1, 32'd1, 0, 0, BR_NONE);
    flush = 1'b0;
    chk("idle_flush", 64'(out_valid), 64'(0));
    chk("idle_flush_hold", 64'(alu_result), 64'd9);

    // Reset mid-DIVU
    issue(EXE_DIVU, 32'd100, 32'd7, 0, 32'h300, BR_JMP);
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstm_valid", 64'(out_valid), 64'(0));
    chk("rstm_res", 64'(alu_result), 64'(0));
    chk("rstm_addr", 64'(br_addr), 64'(0));
    chk("rstm_taken", 64'(br_taken), 64'(0));
    chk("rstm_stall", 64'(stall), 64'(0));
    chk("rstm_cnt", 64'(busy_cnt), 64'(0));
    step();
    chk("rstm_novalid", 64'(out_valid), 64'(0));
    issue(EXE_MFHI, 0, 0, 0, 0, BR_NONE);
    chk("rstm_hi", 64'(alu_result), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
